pwm_cfg_arbiter: RTL and testbench

// - Owns the PWM configuration bank (output enables, PWM enables, duty cycle) and shares its write port between two requesters.
// - Requester 0 is the SPI register decoder; requester 1 is an auxiliary on-chip master (e.g. a sequencer).
// - Writes are staged in shadow registers and committed to the active outputs at a PWM period boundary, so the PWM never sees a mid-period change.
// - A timeout forces the commit when the PWM counter is idle.

---
 rtl/pwm_cfg_arbiter.sv | 177 +++++++++++++++++
 tb/tb_pwm_cfg_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_arbiter.sv
// PWM config bank with round-robin SPI/AUX write port and period-aligned commit.
// PWM_CFG_IMMEDIATE_EN: bypass shadow stage, writes land on active regs at once.
module pwm_cfg_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int TMO_W      = 16,
  parameter int TMO_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr_valid,
  input  logic [ADDR_W-1:0] spi_wr_addr,
  input  logic [DATA_W-1:0] spi_wr_data,
  output logic              spi_wr_ready,
  input  logic              aux_wr_valid,
  input  logic [ADDR_W-1:0] aux_wr_addr,
  input  logic [DATA_W-1:0] aux_wr_data,
  output logic              aux_wr_ready,
  input  logic              period_end,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              cfg_pending,
  output logic [3:0]        wr_err_cnt
);

  localparam int NREG = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_SPI = 2'd1,
    GNT_AUX = 2'd2
  } state_e;

  state_e state_q;
  logic   spi_rdy_q;
  logic   aux_rdy_q;
  logic   last_aux_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      spi_rdy_q  <= 1'b0;
      aux_rdy_q  <= 1'b0;
      last_aux_q <= 1'b1;
    end else begin
      spi_rdy_q <= 1'b0;
      aux_rdy_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (spi_wr_valid && (!aux_wr_valid || last_aux_q)) begin
            state_q    <= GNT_SPI;
            spi_rdy_q  <= 1'b1;
            last_aux_q <= 1'b0;
          end else if (aux_wr_valid) begin
            state_q    <= GNT_AUX;
            aux_rdy_q  <= 1'b1;
            last_aux_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_wr_ready = spi_rdy_q;
  assign aux_wr_ready = aux_rdy_q;

  logic              wr_fire;
  logic              addr_ok;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREG-1:0]   wr_sel;
  logic [3:0]        err_q;
  logic [3:0]        err_d;

  always_comb begin
    wr_fire = (spi_rdy_q & spi_wr_valid) | (aux_rdy_q & aux_wr_valid);
    wr_addr = spi_rdy_q ? spi_wr_addr : aux_wr_addr;
    wr_data = spi_rdy_q ? spi_wr_data : aux_wr_data;
    addr_ok = wr_addr < ADDR_W'(NREG);
    for (int i = 0; i < NREG; i++) begin
      wr_sel[i] = wr_fire && (wr_addr == ADDR_W'(i));
    end
    err_d = err_q;
    if (wr_fire && !addr_ok && err_q != 4'hF) begin
      err_d = err_q + 4'd1;
    end
  end

  logic [NREG-1:0][DATA_W-1:0] act_q;
  logic [NREG-1:0][DATA_W-1:0] act_d;

`ifdef PWM_CFG_IMMEDIATE_EN
  logic unused_pe;
  localparam int unused_tmo = TMO_CYCLES + TMO_W;

  assign unused_pe   = period_end;
  assign cfg_pending = 1'b0;

  always_comb begin
    act_d = act_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_sel[i]) act_d[i] = wr_data;
    end
  end
`else
  logic [NREG-1:0][DATA_W-1:0] shd_q;
  logic [NREG-1:0][DATA_W-1:0] shd_d;
  logic [NREG-1:0]             dirty_q;
  logic [NREG-1:0]             dirty_d;
  logic [TMO_W-1:0]            tmo_q;
  logic [TMO_W-1:0]            tmo_d;
  logic                        tmo_fire;
  logic                        commit;

  assign cfg_pending = |dirty_q;

  // commit reads shadow before this edge's write lands
  always_comb begin
    tmo_fire = 1'b0;
    if (TMO_CYCLES != 0) begin
      tmo_fire = cfg_pending && (tmo_q == TMO_W'(TMO_CYCLES - 1));
    end
    commit = period_end | tmo_fire;
    tmo_d  = '0;
    if (TMO_CYCLES != 0 && cfg_pending && !commit) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
    act_d   = act_q;
    shd_d   = shd_q;
    dirty_d = dirty_q;
    for (int i = 0; i < NREG; i++) begin
      if (commit && dirty_q[i]) begin
        act_d[i]   = shd_q[i];
        dirty_d[i] = 1'b0;
      end
      if (wr_sel[i]) begin
        shd_d[i]   = wr_data;
        dirty_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_q   <= '0;
      dirty_q <= '0;
      tmo_q   <= '0;
    end else begin
      shd_q   <= shd_d;
      dirty_q <= dirty_d;
      tmo_q   <= tmo_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= '0;
      err_q <= '0;
    end else begin
      act_q <= act_d;
      err_q <= err_d;
    end
  end

  assign en_reg_out_7_0  = act_q[0];
  assign en_reg_out_15_8 = act_q[1];
  assign en_reg_pwm_7_0  = act_q[2];
  assign en_reg_pwm_15_8 = act_q[3];
  assign pwm_duty_cycle  = act_q[4];
  assign wr_err_cnt      = err_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Directed + random bench for pwm_cfg_arbiter against a behavioural model.
// Honours PWM_CFG_IMMEDIATE_EN when defined for the build.
module tb_pwm_cfg_arbiter;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       spi_v = 1'b0, aux_v = 1'b0, pe = 1'b0;
  logic [6:0] spi_a = '0, aux_a = '0;
  logic [7:0] spi_d = '0, aux_d = '0;
  logic       spi_rdy, aux_rdy, pend;
  logic [7:0] o0, o1, o2, o3, o4;
  logic [3:0] err;

  int checks = 0;
  int errors = 0;

  pwm_cfg_arbiter #(
    .ADDR_W(7), .DATA_W(8), .TMO_W(16), .TMO_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_wr_valid(spi_v), .spi_wr_addr(spi_a),
    .spi_wr_data(spi_d), .spi_wr_ready(spi_rdy),
    .aux_wr_valid(aux_v), .aux_wr_addr(aux_a),
    .aux_wr_data(aux_d), .aux_wr_ready(aux_rdy),
    .period_end(pe),
    .en_reg_out_7_0(o0), .en_reg_out_15_8(o1),
    .en_reg_pwm_7_0(o2), .en_reg_pwm_15_8(o3),
    .pwm_duty_cycle(o4),
    .cfg_pending(pend), .wr_err_cnt(err)
  );

  always #5 clk = ~clk;

  // model: active/shadow banks, who is ready now, who won last
  logic [7:0] m_act [5];
  logic [7:0] m_shd [5];
  bit         m_dirty [5];
  int         m_gnt, m_last, m_err, m_hs_who;
  longint     edge_n = 0, pend_start = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend();
    for (int i = 0; i < 5; i++) if (m_dirty[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_act[i] = '0; m_shd[i] = '0; m_dirty[i] = 1'b0;
    end
    m_gnt = 0; m_last = 2; m_err = 0; m_hs_who = 0;
  endtask

  task automatic cyc();
    bit pre, commit;
    int ng, hw, wa;
    logic [7:0] wd;
    longint e;
    chk("spi_ready", spi_rdy, m_gnt == 1);
    chk("aux_ready", aux_rdy, m_gnt == 2);
    chk("pending", pend, m_pend());
    chk("out_7_0", o0, m_act[0]);
    chk("out_15_8", o1, m_act[1]);
    chk("pwm_7_0", o2, m_act[2]);
    chk("pwm_15_8", o3, m_act[3]);
    chk("duty", o4, m_act[4]);
    chk("err_cnt", err, m_err);
    hw = 0; wa = 0; wd = '0;
    if (m_gnt == 1 && spi_v) begin
      hw = 1; wa = int'(spi_a); wd = spi_d;
    end else if (m_gnt == 2 && aux_v) begin
      hw = 2; wa = int'(aux_a); wd = aux_d;
    end
    if (m_gnt != 0) ng = 0;
    else if (spi_v && aux_v) ng = (m_last == 2) ? 1 : 2;
    else if (spi_v) ng = 1;
    else if (aux_v) ng = 2;
    else ng = 0;
    pre = m_pend();
    e = edge_n + 1;
`ifdef PWM_CFG_IMMEDIATE_EN
    commit = 1'b0;
`else
    commit = pe || (TMO > 0 && pre && (e - pend_start == TMO));
`endif
    @(posedge clk);
    edge_n = e;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (commit)
        for (int i = 0; i < 5; i++)
          if (m_dirty[i]) begin
            m_act[i] = m_shd[i]; m_dirty[i] = 1'b0;
          end
      if (hw != 0) begin
        if (wa < 5) begin
`ifdef PWM_CFG_IMMEDIATE_EN
          m_act[wa] = wd;
`else
          m_shd[wa] = wd; m_dirty[wa] = 1'b1;
`endif
        end else if (m_err < 15) m_err++;
      end
      if (m_pend() && (!pre || commit)) pend_start = e;
      m_gnt = ng;
      if (ng != 0) m_last = ng;
      m_hs_who = hw;
    end
    @(negedge clk);
  endtask

  task automatic do_wr(int who, int a, int d, bit pe_hs);
    bit done = 1'b0;
    if (who == 1) begin
      spi_v = 1'b1; spi_a = 7'(a); spi_d = 8'(d);
    end else begin
      aux_v = 1'b1; aux_a = 7'(a); aux_d = 8'(d);
    end
    for (int k = 0; k < 8 && !done; k++) begin
      pe = pe_hs && (m_gnt == who);
      cyc();
      pe = 1'b0;
      done = (m_hs_who == who);
    end
    chk("wr_done", done, 1);
    if (who == 1) spi_v = 1'b0; else aux_v = 1'b0;
  endtask

  task automatic pulse_pe();
    pe = 1'b1; cyc(); pe = 1'b0;
  endtask

`ifdef PWM_CFG_IMMEDIATE_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  initial begin
    int spi_at, aux_at, first_who;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_duty", o4, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    cyc();

    // simultaneous requests straight after reset: SPI first
    spi_v = 1'b1; spi_a = 7'd0; spi_d = 8'hAA;
    aux_v = 1'b1; aux_a = 7'd1; aux_d = 8'h55;
    spi_at = -1; aux_at = -1; first_who = 0;
    for (int k = 0; k < 10 && (spi_at < 0 || aux_at < 0); k++) begin
      cyc();
      if (m_hs_who != 0 && first_who == 0) first_who = m_hs_who;
      if (m_hs_who == 1) begin spi_at = k; spi_v = 1'b0; end
      if (m_hs_who == 2) begin aux_at = k; aux_v = 1'b0; end
    end
    spi_v = 1'b0; aux_v = 1'b0;
    chk("rr_first", first_who, 1);
    chk("rr_gap", aux_at - spi_at, 2);
    pulse_pe();
    chk("rr_out0", o0, 8'hAA);
    chk("rr_out1", o1, 8'h55);

    // duty write held until period boundary
    do_wr(1, 4, 8'h80, 1'b0);
    chk("duty_hold", o4, IMM ? 8'h80 : 8'h00);
    chk("duty_pend", pend, !IMM);
    cyc(); cyc();
    pulse_pe();
    chk("duty_commit", o4, 8'h80);
    chk("duty_clear", pend, 0);

    // out-of-range writes saturate the error counter
    for (int k = 0; k < 20; k++) do_wr((k % 2) + 1, 7, k, 1'b0);
    chk("err_sat", err, 4'hF);
    chk("err_no_out", o4, 8'h80);

    // write landing on the same edge as period_end
    do_wr(1, 2, 8'h0F, 1'b1);
    chk("same_edge", o2, IMM ? 8'h0F : 8'h00);
    cyc();
    pulse_pe();
    chk("next_pe", o2, 8'h0F);

    // forced commit via timeout
    do_wr(1, 3, 8'hFF, 1'b0);
    for (int k = 0; k < TMO - 1; k++) cyc();
    chk("tmo_early", o3, IMM ? 8'hFF : 8'h00);
    cyc();
    chk("tmo_fire", o3, 8'hFF);
    chk("tmo_pend", pend, 0);

    // reset while AUX holds the grant
    aux_v = 1'b1; aux_a = 7'd0; aux_d = 8'h33;
    for (int k = 0; k < 8 && m_gnt != 2; k++) cyc();
    chk("rst_in_gnt", m_gnt, 2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_aux_rdy", aux_rdy, 0);
    chk("rst_out0", o0, 0);
    chk("rst_duty2", o4, 0);
    chk("rst_err2", err, 0);
    @(negedge clk);
    cyc();
    aux_v = 1'b0;
    rst_n = 1'b1;
    cyc();
    pulse_pe();
    chk("rst_nowrite", o0, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (!spi_v && $urandom_range(2) == 0) begin
        spi_v = 1'b1; spi_a = 7'($urandom_range(7)); spi_d = 8'($urandom);
      end
      if (!aux_v && $urandom_range(2) == 0) begin
        aux_v = 1'b1; aux_a = 7'($urandom_range(7)); aux_d = 8'($urandom);
      end
      if (spi_v && $urandom_range(24) == 0) spi_v = 1'b0;
      if (aux_v && $urandom_range(24) == 0) aux_v = 1'b0;
      pe = ($urandom_range(11) == 0);
      cyc();
      pe = 1'b0;
      if (m_hs_who == 1) spi_v = 1'b0;
      if (m_hs_who == 2) aux_v = 1'b0;
    end
    spi_v = 1'b0; aux_v = 1'b0;
    for (int k = 0; k < TMO + 4; k++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
